// File: rtl/recover_2n_fft_stream.sv
// recover_2n_fft_stream: streaming 2N-point real-FFT recovery butterfly.
// Each beat carries LANES bins of X1 (even) and X2 (odd) spectra and yields
// X[k] = X1 + W*X2 and X[k+N] = X1 - W*X2 with W = W_2N^k.
// Four-stage pipeline with a global advance; the input is ready whenever
// the output register is free or being drained.
// Optional macro RECOVER_SAT_EN: saturate instead of wrapping when
// OUT_WIDTH < DATA_WIDTH+2.
// The twiddle ROM holds entry k = round(cos/sin(pi*k/N) * 2^SHIFT) and is
// generated at elaboration, so no external image file is needed.
module recover_2n_fft_stream #(
    parameter int DATA_WIDTH = 27,
    parameter int TWID_WIDTH = 16,
    parameter int SHIFT      = 14,
    parameter int OUT_WIDTH  = 32,
    parameter int LANES      = 4,
    parameter int LOG2N      = 13,
    parameter int BITREV_IDX = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LOG2N-1:0]              in_index,
    input  logic [LANES*DATA_WIDTH-1:0]   x1_r,
    input  logic [LANES*DATA_WIDTH-1:0]   x1_i,
    input  logic [LANES*DATA_WIDTH-1:0]   x2_r,
    input  logic [LANES*DATA_WIDTH-1:0]   x2_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LOG2N-1:0]              out_index,
    output logic                          out_last,
    output logic [LANES*OUT_WIDTH-1:0]    lo_r,
    output logic [LANES*OUT_WIDTH-1:0]    lo_i,
    output logic [LANES*OUT_WIDTH-1:0]    hi_r,
    output logic [LANES*OUT_WIDTH-1:0]    hi_i
);
    localparam int N     = 1 << LOG2N;
    localparam int LOG2L = $clog2(LANES);
    localparam int CW    = (LOG2N > LOG2L) ? (LOG2N - LOG2L) : 1;
    localparam int PW    = DATA_WIDTH + TWID_WIDTH + 1;
    localparam int BW    = DATA_WIDTH + 2;
    localparam logic [CW-1:0]        LAST_BEAT = CW'(N / LANES - 1);
    localparam logic signed [PW-1:0] RND       = PW'(64'sd1 <<< (SHIFT - 1));

    genvar gi, gj;

    // Twiddle entry k: {cos, sin} of pi*k/N scaled by 2^SHIFT, rounded to nearest.
    function automatic logic [2*TWID_WIDTH-1:0] twid_entry(input int k);
        real ang, cr, sr, scale;
        int  ci, si;
        scale = real'(64'd1 << SHIFT);
        ang   = 3.141592653589793 * real'(k) / real'(N);
        cr    = $cos(ang) * scale;
        sr    = $sin(ang) * scale;
        ci    = (cr >= 0.0) ? $rtoi(cr + 0.5) : -$rtoi(0.5 - cr);
        si    = (sr >= 0.0) ? $rtoi(sr + 0.5) : -$rtoi(0.5 - sr);
        return {TWID_WIDTH'(ci), TWID_WIDTH'(si)};
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [2*TWID_WIDTH-1:0] twid_rom [N];
    for (gi = 0; gi < N; gi++) begin : g_rom
        assign twid_rom[gi] = twid_entry(gi);
    end

    // Stage 1: captured inputs, natural-order k0 and the per-lane twiddles
    logic                         v1_q, v1_d;
    logic [LOG2N-1:0]             k1_q, k1_d;
    logic signed [DATA_WIDTH-1:0] x1r1_q [LANES], x1r1_d [LANES];
    logic signed [DATA_WIDTH-1:0] x1i1_q [LANES], x1i1_d [LANES];
    logic signed [DATA_WIDTH-1:0] x2r1_q [LANES], x2r1_d [LANES];
    logic signed [DATA_WIDTH-1:0] x2i1_q [LANES], x2i1_d [LANES];
    logic signed [TWID_WIDTH-1:0] c1_q   [LANES], c1_d   [LANES];
    logic signed [TWID_WIDTH-1:0] s1_q   [LANES], s1_d   [LANES];
    // Stage 2: the four raw products
    logic                         v2_q, v2_d;
    logic [LOG2N-1:0]             k2_q, k2_d;
    logic signed [DATA_WIDTH-1:0] x1r2_q [LANES], x1r2_d [LANES];
    logic signed [DATA_WIDTH-1:0] x1i2_q [LANES], x1i2_d [LANES];
    logic signed [PW-1:0]         pcc_q  [LANES], pcc_d  [LANES];
    logic signed [PW-1:0]         pss_q  [LANES], pss_d  [LANES];
    logic signed [PW-1:0]         pic_q  [LANES], pic_d  [LANES];
    logic signed [PW-1:0]         prs_q  [LANES], prs_d  [LANES];
    // Stage 3: rounded W*X2
    logic                         v3_q, v3_d;
    logic [LOG2N-1:0]             k3_q, k3_d;
    logic signed [DATA_WIDTH-1:0] x1r3_q [LANES], x1r3_d [LANES];
    logic signed [DATA_WIDTH-1:0] x1i3_q [LANES], x1i3_d [LANES];
    logic signed [BW-1:0]         tr3_q  [LANES], tr3_d  [LANES];
    logic signed [BW-1:0]         ti3_q  [LANES], ti3_d  [LANES];
    // Stage 4: output registers and frame beat counter
    logic                         out_valid_q, out_valid_d;
    logic [LOG2N-1:0]             out_index_q, out_index_d;
    logic signed [OUT_WIDTH-1:0]  lor_q  [LANES], lor_d  [LANES];
    logic signed [OUT_WIDTH-1:0]  loi_q  [LANES], loi_d  [LANES];
    logic signed [OUT_WIDTH-1:0]  hir_q  [LANES], hir_d  [LANES];
    logic signed [OUT_WIDTH-1:0]  hii_q  [LANES], hii_d  [LANES];
    logic [CW-1:0]                cnt_q, cnt_d;

    logic                         adv;
    logic                         out_hs;
    logic [LOG2N-1:0]             k0_in;
    logic [2*TWID_WIDTH-1:0]      tw_rd [LANES];
    logic signed [OUT_WIDTH-1:0]  nar   [LANES][4];

    assign adv      = !out_valid_q || out_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign in_ready = adv;
    assign k0_in    = (BITREV_IDX != 0) ? bitrev(in_index) : in_index;

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_valid_q && (cnt_q == LAST_BEAT);

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [BW-1:0] bf [4];

        // lane gi sits at bin k0+gi; k0 is lane-aligned so no carry out
        assign tw_rd[gi] = twid_rom[k0_in + LOG2N'(gi)];

        assign bf[0] = BW'(x1r3_q[gi]) + tr3_q[gi];
        assign bf[1] = BW'(x1i3_q[gi]) + ti3_q[gi];
        assign bf[2] = BW'(x1r3_q[gi]) - tr3_q[gi];
        assign bf[3] = BW'(x1i3_q[gi]) - ti3_q[gi];

        for (gj = 0; gj < 4; gj++) begin : g_comp
            if (OUT_WIDTH < BW) begin : g_narrow
`ifdef RECOVER_SAT_EN
                localparam logic signed [BW-1:0] SAT_HI = BW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
                localparam logic signed [BW-1:0] SAT_LO = -SAT_HI - BW'(1);
                assign nar[gi][gj] = (bf[gj] > SAT_HI) ? OUT_WIDTH'(SAT_HI) :
                                     (bf[gj] < SAT_LO) ? OUT_WIDTH'(SAT_LO) :
                                                         OUT_WIDTH'(bf[gj]);
`else
                // two's-complement wrap to the low OUT_WIDTH bits
                assign nar[gi][gj] = OUT_WIDTH'(bf[gj]);
`endif
            end else begin : g_extend
                assign nar[gi][gj] = OUT_WIDTH'(bf[gj]);
            end
        end

        assign lo_r[gi*OUT_WIDTH +: OUT_WIDTH] = lor_q[gi];
        assign lo_i[gi*OUT_WIDTH +: OUT_WIDTH] = loi_q[gi];
        assign hi_r[gi*OUT_WIDTH +: OUT_WIDTH] = hir_q[gi];
        assign hi_i[gi*OUT_WIDTH +: OUT_WIDTH] = hii_q[gi];
    end

    // Next state: every stage moves together on adv; data loads only behind a valid
    always_comb begin
        v1_d = v1_q; k1_d = k1_q;
        x1r1_d = x1r1_q; x1i1_d = x1i1_q; x2r1_d = x2r1_q; x2i1_d = x2i1_q;
        c1_d = c1_q; s1_d = s1_q;
        v2_d = v2_q; k2_d = k2_q; x1r2_d = x1r2_q; x1i2_d = x1i2_q;
        pcc_d = pcc_q; pss_d = pss_q; pic_d = pic_q; prs_d = prs_q;
        v3_d = v3_q; k3_d = k3_q; x1r3_d = x1r3_q; x1i3_d = x1i3_q;
        tr3_d = tr3_q; ti3_d = ti3_q;
        out_valid_d = out_valid_q; out_index_d = out_index_q;
        lor_d = lor_q; loi_d = loi_q; hir_d = hir_q; hii_d = hii_q;
        cnt_d = cnt_q;

        if (out_hs) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CW'(1);

        if (adv) begin
            v1_d        = in_valid;
            v2_d        = v1_q;
            v3_d        = v2_q;
            out_valid_d = v3_q;
            if (in_valid) begin
                k1_d = k0_in;
                for (int l = 0; l < LANES; l++) begin
                    x1r1_d[l] = x1_r[l*DATA_WIDTH +: DATA_WIDTH];
                    x1i1_d[l] = x1_i[l*DATA_WIDTH +: DATA_WIDTH];
                    x2r1_d[l] = x2_r[l*DATA_WIDTH +: DATA_WIDTH];
                    x2i1_d[l] = x2_i[l*DATA_WIDTH +: DATA_WIDTH];
                    c1_d[l]   = tw_rd[l][2*TWID_WIDTH-1:TWID_WIDTH];
                    s1_d[l]   = tw_rd[l][TWID_WIDTH-1:0];
                end
            end
            if (v1_q) begin
                k2_d = k1_q; x1r2_d = x1r1_q; x1i2_d = x1i1_q;
                for (int l = 0; l < LANES; l++) begin
                    pcc_d[l] = PW'(x2r1_q[l]) * PW'(c1_q[l]);
                    pss_d[l] = PW'(x2i1_q[l]) * PW'(s1_q[l]);
                    pic_d[l] = PW'(x2i1_q[l]) * PW'(c1_q[l]);
                    prs_d[l] = PW'(x2r1_q[l]) * PW'(s1_q[l]);
                end
            end
            if (v2_q) begin
                k3_d = k2_q; x1r3_d = x1r2_q; x1i3_d = x1i2_q;
                for (int l = 0; l < LANES; l++) begin
                    // W = c - j*s, so W*X2 = (xr*c + xi*s) + j(xi*c - xr*s); round half up
                    tr3_d[l] = BW'((pcc_q[l] + pss_q[l] + RND) >>> SHIFT);
                    ti3_d[l] = BW'((pic_q[l] - prs_q[l] + RND) >>> SHIFT);
                end
            end
            if (v3_q) begin
                out_index_d = k3_q;
                for (int l = 0; l < LANES; l++) begin
                    lor_d[l] = nar[l][0];
                    loi_d[l] = nar[l][1];
                    hir_d[l] = nar[l][2];
                    hii_d[l] = nar[l][3];
                end
            end
        end
    end

    // State registers; asynchronous reset drops all in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; k1_q <= '0;
            x1r1_q <= '{default: '0}; x1i1_q <= '{default: '0};
            x2r1_q <= '{default: '0}; x2i1_q <= '{default: '0};
            c1_q <= '{default: '0}; s1_q <= '{default: '0};
            v2_q <= 1'b0; k2_q <= '0;
            x1r2_q <= '{default: '0}; x1i2_q <= '{default: '0};
            pcc_q <= '{default: '0}; pss_q <= '{default: '0};
            pic_q <= '{default: '0}; prs_q <= '{default: '0};
            v3_q <= 1'b0; k3_q <= '0;
            x1r3_q <= '{default: '0}; x1i3_q <= '{default: '0};
            tr3_q <= '{default: '0}; ti3_q <= '{default: '0};
            out_valid_q <= 1'b0; out_index_q <= '0;
            lor_q <= '{default: '0}; loi_q <= '{default: '0};
            hir_q <= '{default: '0}; hii_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            v1_q <= v1_d; k1_q <= k1_d;
            x1r1_q <= x1r1_d; x1i1_q <= x1i1_d; x2r1_q <= x2r1_d; x2i1_q <= x2i1_d;
            c1_q <= c1_d; s1_q <= s1_d;
            v2_q <= v2_d; k2_q <= k2_d; x1r2_q <= x1r2_d; x1i2_q <= x1i2_d;
            pcc_q <= pcc_d; pss_q <= pss_d; pic_q <= pic_d; prs_q <= prs_d;
            v3_q <= v3_d; k3_q <= k3_d; x1r3_q <= x1r3_d; x1i3_q <= x1i3_d;
            tr3_q <= tr3_d; ti3_q <= ti3_d;
            out_valid_q <= out_valid_d; out_index_q <= out_index_d;
            lor_q <= lor_d; loi_q <= loi_d; hir_q <= hir_d; hii_q <= hii_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
